// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared FSM state type, RV64 funct3 codes and size helpers for dmem_responder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Access size comes from funct3[1:0] for both signed and unsigned forms
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         2'b10:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] off, input logic [2:0] funct3);
      logic [3:0] w_mask;
      w_mask = size_bytes(funct3) - 4'd1;
      return ({1'b0, off} & w_mask) != 4'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module  : dmem_lane_align
// Brief   : Combinational byte-lane merge for stores and extract/extend for loads.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  off,
   input  logic [2:0]  funct3,
   input  logic [63:0] word,
   input  logic [63:0] wdata,
   output logic [63:0] store_word,
   output logic [63:0] load_data
);

   logic [5:0]  w_shift;
   logic [63:0] w_size_mask;
   logic [63:0] w_lane_mask;
   logic [63:0] w_raw;

   assign w_shift = {off, 3'b000};

   always_comb begin
      w_size_mask = '1;
      case (funct3[1:0])
         2'b00:   w_size_mask = 64'h0000_0000_0000_00FF;
         2'b01:   w_size_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   w_size_mask = 64'h0000_0000_FFFF_FFFF;
         default: w_size_mask = '1;
      endcase
   end

   assign w_lane_mask = w_size_mask << w_shift;
   assign store_word  = (word & ~w_lane_mask) | ((wdata & w_size_mask) << w_shift);
   assign w_raw       = word >> w_shift;

   always_comb begin
      load_data = '0;
      case (funct3)
         F3_B:    load_data = {{56{w_raw[7]}},  w_raw[7:0]};
         F3_H:    load_data = {{48{w_raw[15]}}, w_raw[15:0]};
         F3_W:    load_data = {{32{w_raw[31]}}, w_raw[31:0]};
         F3_D:    load_data = w_raw;
         F3_BU:   load_data = {56'd0, w_raw[7:0]};
         F3_HU:   load_data = {48'd0, w_raw[15:0]};
         F3_WU:   load_data = {32'd0, w_raw[31:0]};
         default: load_data = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : Fixed-latency RV64 load/store responder; DMEM_MISALIGN_TRAP_EN traps misalignment.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [63:0]       req_wdata,
   output logic              rsp_valid,
   output logic [63:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int         DEPTH      = 2 ** (ADDR_W - 3);
   localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_funct3;
   logic [63:0]         r_wdata;
   logic [63:0]         r_mem [DEPTH];

   logic                w_accept;
   logic                w_access;
   logic                w_use_req;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic [2:0]          w_funct3;
   logic [63:0]         w_wdata;
   logic [63:0]         w_word;
   logic [2:0]          w_off;
   logic                w_mis;
   logic                w_bad_f3;
   logic                w_err;
   logic [63:0]         w_store_word;
   logic [63:0]         w_load_data;

   assign req_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign w_accept  = (r_state == ST_IDLE) && req_valid;

   // With LATENCY 1 the access happens on the accept edge, straight from req_*
   assign w_access  = (LATENCY == 1) ? w_accept : ((r_state == ST_WAIT) && (r_cnt == 4'd1));
   assign w_use_req = (r_state == ST_IDLE);
   assign w_we      = w_use_req ? req_we     : r_we;
   assign w_addr    = w_use_req ? req_addr   : r_addr;
   assign w_funct3  = w_use_req ? req_funct3 : r_funct3;
   assign w_wdata   = w_use_req ? req_wdata  : r_wdata;
   assign w_word    = r_mem[w_addr[ADDR_W-1:3]];

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_mis = is_misaligned(w_addr[2:0], w_funct3);
   assign w_off = w_addr[2:0];
`else
   assign w_mis = 1'b0;
   assign w_off = w_addr[2:0] & ~3'(size_bytes(w_funct3) - 4'd1);
`endif

   assign w_bad_f3 = w_we ? w_funct3[2] : (w_funct3 == 3'b111);
   assign w_err    = w_bad_f3 || w_mis;

   dmem_lane_align u_lane_align (
      .off        (w_off),
      .funct3     (w_funct3),
      .word       (w_word),
      .wdata      (w_wdata),
      .store_word (w_store_word),
      .load_data  (w_load_data)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_funct3  <= 3'd0;
         r_wdata   <= 64'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 64'd0;
         rsp_err   <= 1'b0;
      end else begin
         r_state   <= w_next;
         rsp_valid <= w_access;
         if (w_accept) begin
            r_cnt    <= C_CNT_INIT;
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access) begin
            rsp_rdata <= (w_we || w_err) ? 64'd0 : w_load_data;
            rsp_err   <= w_err;
         end
      end
   end

   // RAM is not reset; writes are suppressed while reset is held
   always_ff @(posedge clk) begin
      if (reset_n && w_access && w_we && !w_err)
         r_mem[w_addr[ADDR_W-1:3]] <= w_store_word;
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Table-driven scoreboard bench for dmem_responder (LATENCY 2).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

   localparam int ADDR_W  = 8;
   localparam int LATENCY = 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [2:0]        req_funct3 = 3'd0;
   logic [63:0]       req_wdata = 64'd0;
   logic              rsp_valid;
   logic [63:0]       rsp_rdata;
   logic              rsp_err;
   logic              busy;

   dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [2:0]  f3;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   resp_count = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && rsp_valid) begin
         exp_t e;
         resp_count++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: got rdata 0x%016h err %0b with nothing outstanding",
                     rsp_rdata, rsp_err);
         end else begin
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
               n_fail++;
               $display("FAIL rsp: got rdata 0x%016h err %0b expected rdata 0x%016h err %0b",
                        rsp_rdata, rsp_err, e.rdata, e.err);
            end
         end
      end
   end

   task automatic drive(input vec_t v);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_addr   = v.addr;
      req_funct3 = v.f3;
      req_wdata  = v.wdata;
   endtask

   task automatic send(input vec_t v);
      int n;
      n = 0;
      drive(v);
      exp_q.push_back({v.exp_rdata, v.exp_err});
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("rsp_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   acc_edges[$];
      int   base;

      // Loads against the word written at 0x08, then lane-level stores
      tbl.push_back('{0, 8'h0F, 3'b000, 64'd0, 64'hFFFF_FFFF_FFFF_FF88, 0});
      tbl.push_back('{0, 8'h0F, 3'b100, 64'd0, 64'h0000_0000_0000_0088, 0});
      tbl.push_back('{0, 8'h0E, 3'b001, 64'd0, 64'hFFFF_FFFF_FFFF_8877, 0});
      tbl.push_back('{0, 8'h0E, 3'b101, 64'd0, 64'h0000_0000_0000_8877, 0});
      tbl.push_back('{0, 8'h0C, 3'b110, 64'd0, 64'h0000_0000_8877_6655, 0});
      tbl.push_back('{0, 8'h0C, 3'b010, 64'd0, 64'hFFFF_FFFF_8877_6655, 0});
      tbl.push_back('{0, 8'h08, 3'b011, 64'd0, 64'h8877_6655_4433_2211, 0});
`ifdef DMEM_MISALIGN_TRAP_EN
      tbl.push_back('{0, 8'h0A, 3'b010, 64'd0, 64'd0, 1});
`else
      tbl.push_back('{0, 8'h0A, 3'b010, 64'd0, 64'h0000_0000_4433_2211, 0});
`endif
      tbl.push_back('{0, 8'h08, 3'b111, 64'd0, 64'd0, 1});
      tbl.push_back('{1, 8'h09, 3'b000, 64'h0000_0000_0000_00AA, 64'd0, 0});
      tbl.push_back('{0, 8'h08, 3'b011, 64'd0, 64'h8877_6655_4433_AA11, 0});
      tbl.push_back('{1, 8'h00, 3'b011, 64'd0, 64'd0, 0});
      tbl.push_back('{1, 8'h02, 3'b001, 64'h0000_0000_1234_BEEF, 64'd0, 0});
      tbl.push_back('{0, 8'h00, 3'b011, 64'd0, 64'h0000_0000_BEEF_0000, 0});
      tbl.push_back('{1, 8'h04, 3'b010, 64'hFFFF_FFFF_CAFE_F00D, 64'd0, 0});
      tbl.push_back('{0, 8'h00, 3'b011, 64'd0, 64'hCAFE_F00D_BEEF_0000, 0});
      tbl.push_back('{0, 8'h04, 3'b010, 64'd0, 64'hFFFF_FFFF_CAFE_F00D, 0});
      tbl.push_back('{1, 8'h00, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1});
      tbl.push_back('{0, 8'h00, 3'b011, 64'd0, 64'hCAFE_F00D_BEEF_0000, 0});
`ifdef DMEM_MISALIGN_TRAP_EN
      tbl.push_back('{1, 8'h01, 3'b001, 64'h0000_0000_0000_5566, 64'd0, 1});
      tbl.push_back('{0, 8'h00, 3'b011, 64'd0, 64'hCAFE_F00D_BEEF_0000, 0});
`else
      tbl.push_back('{1, 8'h01, 3'b001, 64'h0000_0000_0000_5566, 64'd0, 0});
      tbl.push_back('{0, 8'h00, 3'b011, 64'd0, 64'hCAFE_F00D_BEEF_5566, 0});
`endif

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_ready", 64'(req_ready), 64'd1);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_rdata", rsp_rdata, 64'd0);
      chk("reset_rsp_err", 64'(rsp_err), 64'd0);

      // First SD with cycle-by-cycle timing
      drive('{1, 8'h08, 3'b011, 64'h8877_6655_4433_2211, 64'd0, 0});
      exp_q.push_back({64'd0, 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_ready", 64'(req_ready), 64'd0);
      chk("t1_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
      chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t2_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("t3_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t3_busy", 64'(busy), 64'd0);
      chk("t3_ready", 64'(req_ready), 64'd1);
      drain();

      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i]);
         drain();
      end

      // req_valid held high: accepts must be LATENCY+1 edges apart
      base = resp_count;
      drive('{0, 8'h08, 3'b011, 64'd0, 64'd0, 0});
      for (int e = 0; e < 9; e++) begin
         if (req_ready) begin
            exp_q.push_back({64'h8877_6655_4433_AA11, 1'b0});
            acc_edges.push_back(e);
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      drain();
      chk("hold_accepts", 64'(acc_edges.size()), 64'd3);
      if (acc_edges.size() >= 2)
         chk("hold_spacing", 64'(acc_edges[1] - acc_edges[0]), 64'(LATENCY + 1));
      chk("hold_responses", 64'(resp_count - base), 64'(acc_edges.size()));

      // Reset during WAIT drops the store
      send('{1, 8'h10, 3'b011, 64'h0123_4567_89AB_CDEF, 64'd0, 0});
      drain();
      base = resp_count;
      drive('{1, 8'h10, 3'b011, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_pre_busy", 64'(busy), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_async_busy", 64'(busy), 64'd0);
      chk("rst_async_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_no_rsp", 64'(resp_count - base), 64'd0);
      send('{0, 8'h10, 3'b011, 64'd0, 64'h0123_4567_89AB_CDEF, 0});
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
